floo_rob_slot_alloc: RTL and testbench

FLOO_ROB_SLOT_ALLOC -- requirements
Module: floo_rob_slot_alloc

---
 rtl/floo_rob_slot_alloc.sv | 131 +++++++++++++
 tb/tb_floo_rob_slot_alloc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/floo_rob_slot_alloc.sv
// Reorder-buffer slot allocator: hands out contiguous ring slots per burst and retires them in order.
// Optional peak-occupancy statistics are enabled by defining FLOO_ROB_ALLOC_STATS_EN.
module floo_rob_slot_alloc #(
    parameter int unsigned ReorderBufferSize = 64,
    parameter int unsigned LenWidth          = 8,
    localparam int unsigned IdxW             = $clog2(ReorderBufferSize),
    localparam int unsigned CntW             = IdxW + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [LenWidth-1:0] alloc_len_i,
    output logic [IdxW-1:0]     alloc_idx_o,
    input  logic                free_i,
    input  logic                flush_i,
    output logic                flush_done_o,
    output logic [CntW-1:0]     free_cnt_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                err_o,
    output logic [CntW-1:0]     peak_occ_o
);

    // Wide enough for both len+1 and the slot count, so the comparisons never truncate.
    localparam int unsigned WW = ((LenWidth + 1) > CntW) ? (LenWidth + 1) : CntW;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IdxW-1:0] r_head;
    logic [IdxW-1:0] r_tail;
    logic [CntW-1:0] r_occ;
    logic            r_err;
    logic [IdxW-1:0] w_head_next;
    logic [IdxW-1:0] w_tail_next;
    logic [CntW-1:0] w_occ_next;
    logic            w_err_next;
    logic [WW-1:0]   w_need;
    logic [CntW-1:0] w_free_cnt;
    logic            w_ready;
    logic            w_hs;
    logic            w_free_ok;
    logic            w_oversize;

    assign w_need     = WW'(alloc_len_i) + WW'(1);
    assign w_free_cnt = CntW'(ReorderBufferSize) - r_occ;
    assign w_oversize = w_need > WW'(ReorderBufferSize);
    // Gated by rst_ni so the port reads 0 while reset is held.
    assign w_ready    = rst_ni && (r_state == ACTIVE) && (WW'(w_free_cnt) >= w_need);
    assign w_hs       = alloc_valid_i && w_ready;
    assign w_free_ok  = free_i && (r_occ != '0);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ACTIVE:  if (flush_i) w_state_next = DRAIN;
            DRAIN:   if (r_occ == '0) w_state_next = CLEAR;
            CLEAR:   w_state_next = ACTIVE;
            default: w_state_next = ACTIVE;
        endcase
    end

    always_comb begin
        w_head_next = r_head;
        w_tail_next = r_tail;
        w_occ_next  = r_occ;
        w_err_next  = r_err;
        if (w_hs) begin
            w_tail_next = r_tail + w_need[IdxW-1:0];
        end
        if (w_free_ok) begin
            w_head_next = r_head + IdxW'(1);
        end
        // need never exceeds the free count on a handshake, so CntW bits suffice.
        w_occ_next = r_occ + (w_hs ? w_need[CntW-1:0] : '0) - (w_free_ok ? CntW'(1) : '0);
        if ((free_i && (r_occ == '0)) || (alloc_valid_i && w_oversize)) begin
            w_err_next = 1'b1;
        end
        if (r_state == CLEAR) begin
            w_head_next = '0;
            w_tail_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ACTIVE;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_occ   <= w_occ_next;
            r_err   <= w_err_next;
        end
    end

`ifdef FLOO_ROB_ALLOC_STATS_EN
    logic [CntW-1:0] r_peak;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_peak <= '0;
        end else if (w_occ_next > r_peak) begin
            r_peak <= w_occ_next;
        end
    end

    assign peak_occ_o = r_peak;
`else
    assign peak_occ_o = '0;
`endif

    assign alloc_ready_o = w_ready;
    assign alloc_idx_o   = r_tail;
    assign flush_done_o  = (r_state == CLEAR);
    assign free_cnt_o    = w_free_cnt;
    assign empty_o       = (r_occ == '0);
    assign full_o        = (r_occ == CntW'(ReorderBufferSize));
    assign err_o         = r_err;

endmodule

// File: tb/tb_floo_rob_slot_alloc.sv
// Directed self-checking bench for floo_rob_slot_alloc (Size=64, LenWidth=8).
module tb_floo_rob_slot_alloc;

    localparam int unsigned SIZE = 64;
    localparam int unsigned LW   = 8;
    localparam int unsigned IW   = 6;
    localparam int unsigned CW   = 7;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          alloc_valid_i = 1'b0;
    logic          alloc_ready_o;
    logic [LW-1:0] alloc_len_i = '0;
    logic [IW-1:0] alloc_idx_o;
    logic          free_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic [CW-1:0] free_cnt_o;
    logic          empty_o;
    logic          full_o;
    logic          err_o;
    logic [CW-1:0] peak_occ_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    floo_rob_slot_alloc #(
        .ReorderBufferSize(SIZE),
        .LenWidth         (LW)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_valid_i(alloc_valid_i),
        .alloc_ready_o(alloc_ready_o),
        .alloc_len_i  (alloc_len_i),
        .alloc_idx_o  (alloc_idx_o),
        .free_i       (free_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .free_cnt_o   (free_cnt_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .err_o        (err_o),
        .peak_occ_o   (peak_occ_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid_i = 1'b0;
        alloc_len_i   = '0;
        free_i        = 1'b0;
        flush_i       = 1'b0;
        rst_ni        = 1'b0;
        #1;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic alloc(input int len);
        alloc_valid_i = 1'b1;
        alloc_len_i   = LW'(len);
        step();
        alloc_valid_i = 1'b0;
        alloc_len_i   = '0;
    endtask

    task automatic do_free(input int n);
        free_i = 1'b1;
        for (int i = 0; i < n; i++) step();
        free_i = 1'b0;
    endtask

    initial begin
        // Reset values while held
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_ready", 32'(alloc_ready_o), 0);
        chk("rst_flush_done", 32'(flush_done_o), 0);
        chk("rst_free_cnt", 32'(free_cnt_o), 64);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_idx", 32'(alloc_idx_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_peak", 32'(peak_occ_o), 0);
        step();
        rst_ni = 1'b1;
        #1;
        chk("post_rst_ready", 32'(alloc_ready_o), 1);

        // Back-to-back allocations
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd3;
        chk("a1_idx", 32'(alloc_idx_o), 0);
        step();
        alloc_len_i = 8'd0;
        chk("a2_idx", 32'(alloc_idx_o), 4);
        step();
        alloc_valid_i = 1'b0;
        chk("a2_free_cnt", 32'(free_cnt_o), 59);
        chk("a2_tail", 32'(alloc_idx_o), 5);

        // Ring wrap of the tail pointer
        do_reset();
        alloc(61);
        chk("wrap_idx62", 32'(alloc_idx_o), 62);
        do_free(62);
        chk("wrap_empty", 32'(empty_o), 1);
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd7;
        chk("wrap_grant_idx", 32'(alloc_idx_o), 62);
        step();
        alloc_valid_i = 1'b0;
        chk("wrap_tail", 32'(alloc_idx_o), 6);
        chk("wrap_free_cnt", 32'(free_cnt_o), 56);

        // Insufficient space, then a free makes room on the following cycle
        do_reset();
        alloc(59);
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd4;
        free_i        = 1'b1;
        chk("near_full_ready", 32'(alloc_ready_o), 0);
        step();
        free_i = 1'b0;
        chk("after_free_ready", 32'(alloc_ready_o), 1);
        step();
        alloc_valid_i = 1'b0;
        chk("full_flag", 32'(full_o), 1);
        chk("full_free_cnt", 32'(free_cnt_o), 0);
        chk("full_tail", 32'(alloc_idx_o), 1);
        chk("full_no_err", 32'(err_o), 0);

        // Simultaneous handshake and free
        do_reset();
        alloc(9);
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd1;
        free_i        = 1'b1;
        step();
        alloc_valid_i = 1'b0;
        free_i        = 1'b0;
        chk("hs_free_cnt", 32'(free_cnt_o), 53);
        chk("hs_free_tail", 32'(alloc_idx_o), 12);

        // Flush with a same-cycle handshake, drain, clear
        do_reset();
        alloc(2);
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd0;
        flush_i       = 1'b1;
        step();
        alloc_valid_i = 1'b0;
        flush_i       = 1'b0;
        chk("flush_hs_taken", 32'(free_cnt_o), 60);
        chk("drain_ready", 32'(alloc_ready_o), 0);
        do_free(4);
        chk("drain_empty", 32'(empty_o), 1);
        chk("drain_no_done", 32'(flush_done_o), 0);
        step();
        chk("clear_done", 32'(flush_done_o), 1);
        step();
        chk("done_pulse_end", 32'(flush_done_o), 0);
        chk("clear_idx", 32'(alloc_idx_o), 0);
        chk("clear_ready", 32'(alloc_ready_o), 1);

        // Free while empty is an error, and the error is sticky
        do_free(1);
        chk("empty_free_err", 32'(err_o), 1);
        chk("empty_free_cnt", 32'(free_cnt_o), 64);
        step();
        chk("err_sticky", 32'(err_o), 1);

        // Oversized burst is refused; exact-size burst fills the ring
        do_reset();
        chk("reset_clears_err", 32'(err_o), 0);
        alloc_valid_i = 1'b1;
        alloc_len_i   = 8'd64;
        chk("oversize_ready", 32'(alloc_ready_o), 0);
        step();
        alloc_valid_i = 1'b0;
        chk("oversize_err", 32'(err_o), 1);
        chk("oversize_free_cnt", 32'(free_cnt_o), 64);
        do_reset();
        alloc(63);
        chk("exact_full", 32'(full_o), 1);
        chk("exact_tail", 32'(alloc_idx_o), 0);
        do_free(64);
        chk("exact_drained", 32'(free_cnt_o), 64);
`ifdef FLOO_ROB_ALLOC_STATS_EN
        chk("peak", 32'(peak_occ_o), 64);
`else
        chk("peak_tied", 32'(peak_occ_o), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
